sync_fifo_param: RTL

//  Parametrised single-clock FIFO; next generation of the FIFO family for same-clock-domain paths.

---
 rtl/sync_fifo_param.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO for same-clock-domain paths.
//   Registered occupancy count, programmable almost-full / almost-empty flags
//   and a read-valid strobe. All flags are registered and derived from the
//   next-state count, so they line up with count in the same cycle.
//
// Build option:
//   SYNC_FIFO_ERR_EN  when defined, adds sticky overflow/underflow error
//                     registers and protocol assertions. When undefined,
//                     overflow/underflow are tied low. Data path and flags
//                     are identical in both builds.
//
// Parameters:
//   DATA_W     data width in bits
//   DEPTH      number of entries (power of 2, >= 4)
//   AF_THRESH  walmost_full when count >= AF_THRESH
//   AE_THRESH  ralmost_empty when count <= AE_THRESH
//
// Ports:
//   clk            in   1            single clock, posedge
//   rst            in   1            synchronous active-high reset
//   winc           in   1            write request
//   wdata          in   DATA_W       write data
//   wfull          out  1            count == DEPTH
//   walmost_full   out  1            count >= AF_THRESH
//   rinc           in   1            read request
//   rdata          out  DATA_W       registered read data
//   rvalid         out  1            rdata updated this cycle
//   rempty         out  1            count == 0
//   ralmost_empty  out  1            count <= AE_THRESH
//   count          out  CNT_W        occupancy 0..DEPTH
//   overflow       out  1            sticky write-while-full
//   underflow      out  1            sticky read-while-empty
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     winc,
    input  logic [DATA_W-1:0]        wdata,
    output logic                     wfull,
    output logic                     walmost_full,
    input  logic                     rinc,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    output logic                     rempty,
    output logic                     ralmost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  C_AF    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0]  C_AE    = CNT_W'(AE_THRESH);
    localparam logic [CNT_W-1:0]  C_ZERO  = '0;
    localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] C_PINC  = ADDR_W'(1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
    end

    if (!((AE_THRESH > 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresh
        $error("sync_fifo_param: require 0 < AE_THRESH < AF_THRESH <= DEPTH");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;

    logic              w_wr_en;
    logic              w_rd_en;
    logic [CNT_W-1:0]  w_count_nxt;

    // Full gates writes even when a read is accepted in the same cycle, and
    // empty gates reads even when a write arrives: no fall-through path.
    assign w_wr_en = winc & ~r_full;
    assign w_rd_en = rinc & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_count_nxt = r_count + C_ONE;
            2'b01:   w_count_nxt = r_count - C_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: not reset. Reset still blocks a concurrent write so that
    // contents only ever change through an accepted write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, count, read port and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + C_PINC;
            end
            if (w_rd_en) begin
                r_rptr  <= r_rptr + C_PINC;
                r_rdata <= r_mem[r_rptr];
            end
            r_rvalid <= w_rd_en;
            r_count  <= w_count_nxt;
            // Flags come from the next count so they track count exactly.
            r_full   <= (w_count_nxt == C_DEPTH);
            r_empty  <= (w_count_nxt == C_ZERO);
            r_afull  <= (w_count_nxt >= C_AF);
            r_aempty <= (w_count_nxt <= C_AE);
        end
    end

    assign wfull         = r_full;
    assign rempty        = r_empty;
    assign walmost_full  = r_afull;
    assign ralmost_empty = r_aempty;
    assign rdata         = r_rdata;
    assign rvalid        = r_rvalid;
    assign count         = r_count;

    // ------------------------------------------------------------------
    // Optional error capture and protocol checks
    // ------------------------------------------------------------------
`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc && r_full) begin
                r_overflow <= 1'b1;
            end
            if (rinc && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    a_wdata_known : assert property (@(posedge clk) disable iff (rst)
        winc |-> !$isunknown(wdata));

    a_not_full_and_empty : assert property (@(posedge clk) disable iff (rst)
        !(r_empty && r_full));

    a_rdata_known : assert property (@(posedge clk) disable iff (rst)
        r_rvalid |-> !$isunknown(r_rdata));
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
